// File: rtl/md_unit_if.sv
// Pipeline-facing bundle for the multiply/divide unit.
// It carries the E-stage issue, the D-stage hazard hint, HI/LO and busy/stall back.
interface md_unit_if;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] a;
   logic [31:0] b;
   logic        d_md_use;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        m_stall;

   modport master (
      output start, md_op, a, b, d_md_use,
      input  hi, lo, busy, m_stall
   );

   modport slave (
      input  start, md_op, a, b, d_md_use,
      output hi, lo, busy, m_stall
   );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle MULT/DIV unit owning HI/LO. Results are computed at issue and held in tmp
// registers, then committed after a fixed latency. It raises m_stall for HI/LO users in D.
module md_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input logic      clk,
   input logic      reset,
   md_unit_if.slave md
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state, next_state;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [31:0]        hi_q, hi_nxt, lo_q, lo_nxt;
   logic [31:0]        hi_tmp, hi_tmp_nxt, lo_tmp, lo_tmp_nxt;
   logic               busy_q, busy_nxt;

   logic [63:0]        prod_s, prod_u;
   logic               div_zero, div_ovf;
   logic [31:0]        sdiv_b, udiv_b;
   logic signed [31:0] quot_s, rem_s;
   logic [31:0]        quot_u, rem_u;

   // Divisors are steered to 1 for the zero and overflow cases so the divider never sees them;
   // the overflow result then falls out as a/1 = 0x80000000 rem 0.
   assign div_zero = (md.b == 32'd0);
   assign div_ovf  = (md.a == 32'h8000_0000) && (md.b == 32'hFFFF_FFFF);
   assign sdiv_b   = (div_zero || div_ovf) ? 32'd1 : md.b;
   assign udiv_b   = div_zero ? 32'd1 : md.b;

   assign prod_s = 64'($signed({{32{md.a[31]}}, md.a}) * $signed({{32{md.b[31]}}, md.b}));
   assign prod_u = {32'd0, md.a} * {32'd0, md.b};
   assign quot_s = $signed(md.a) / $signed(sdiv_b);
   assign rem_s  = $signed(md.a) % $signed(sdiv_b);
   assign quot_u = md.a / udiv_b;
   assign rem_u  = md.a % udiv_b;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= IDLE;
         cnt    <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         hi_tmp <= '0;
         lo_tmp <= '0;
         busy_q <= 1'b0;
      end else begin
         state  <= next_state;
         cnt    <= cnt_nxt;
         hi_q   <= hi_nxt;
         lo_q   <= lo_nxt;
         hi_tmp <= hi_tmp_nxt;
         lo_tmp <= lo_tmp_nxt;
         busy_q <= busy_nxt;
      end
   end

   always_comb begin
      next_state = state;
      cnt_nxt    = cnt;
      hi_nxt     = hi_q;
      lo_nxt     = lo_q;
      hi_tmp_nxt = hi_tmp;
      lo_tmp_nxt = lo_tmp;

      case (state)
         IDLE: begin
            if (md.start) begin
               case (md.md_op)
                  OP_MULT: begin
                     {hi_tmp_nxt, lo_tmp_nxt} = prod_s;
                     cnt_nxt    = CNT_W'(MULT_CYCLES);
                     next_state = RUN;
                  end
                  OP_MULTU: begin
                     {hi_tmp_nxt, lo_tmp_nxt} = prod_u;
                     cnt_nxt    = CNT_W'(MULT_CYCLES);
                     next_state = RUN;
                  end
                  OP_DIV: begin
                     if (div_zero) begin
                        hi_tmp_nxt = hi_q;
                        lo_tmp_nxt = lo_q;
                     end else begin
                        hi_tmp_nxt = 32'(rem_s);
                        lo_tmp_nxt = 32'(quot_s);
                     end
                     cnt_nxt    = CNT_W'(DIV_CYCLES);
                     next_state = RUN;
                  end
                  OP_DIVU: begin
                     if (div_zero) begin
                        hi_tmp_nxt = hi_q;
                        lo_tmp_nxt = lo_q;
                     end else begin
                        hi_tmp_nxt = rem_u;
                        lo_tmp_nxt = quot_u;
                     end
                     cnt_nxt    = CNT_W'(DIV_CYCLES);
                     next_state = RUN;
                  end
                  OP_MTHI: hi_nxt = md.a;
                  OP_MTLO: lo_nxt = md.a;
                  default: ;
               endcase
            end
         end
         RUN: begin
            cnt_nxt = cnt - CNT_W'(1);
            if (cnt <= CNT_W'(1)) begin
               hi_nxt     = hi_tmp;
               lo_nxt     = lo_tmp;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase

      busy_nxt = (next_state == RUN);
   end

   assign md.hi      = hi_q;
   assign md.lo      = lo_q;
   assign md.busy    = busy_q;
   assign md.m_stall = md.d_md_use & (busy_q | (md.start & (md.md_op <= OP_DIVU)));

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit for the P6 pipeline. It executes MULT/MULTU/DIV/DIVU/MTHI/MTLO issued from the E stage and holds the HI/LO registers. It generates `m_stall`, the multi-cycle hazard stall that freezes the PC and the F/D pipeline registers while a HI/LO-dependent instruction waits in D.

## Interface

Parameters:
- `MULT_CYCLES`, default 5: busy duration of MULT/MULTU, in cycles (≥1).
- `DIV_CYCLES`, default 10: busy duration of DIV/DIVU, in cycles (≥1).

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-low (reset when `reset==0` at a rising edge).
- `start` input 1: E-stage instruction is an MD op this cycle. Single-cycle pulse per instruction.
- `md_op` input 3: operation code. 0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO. 6–7 are no-ops.
- `a` input 32: rs operand, already forwarded.
- `b` input 32: rt operand, already forwarded.
- `d_md_use` input 1: D-stage instruction is MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO.
- `hi` output 32: HI register.
- `lo` output 32: LO register.
- `busy` output 1: multi-cycle operation in progress.
- `m_stall` output 1: stall request to PC and F/D registers.

## Operation

- State: `IDLE`, `RUN`. Registers: `hi`, `lo`, `cnt` (width to hold max(MULT_CYCLES, DIV_CYCLES)), `hi_tmp`, `lo_tmp`, `busy`.
- Accepted start: `start==1` while in `IDLE`. A `start` seen in `RUN` is ignored entirely, with no effect on state, `hi`, or `lo`. The pipeline never issues one there because `m_stall` prevents it.
- In `IDLE` with an accepted start:
  - MULT: `{hi_tmp,lo_tmp} <= $signed(a)*$signed(b)`, a 64-bit product. `cnt <= MULT_CYCLES`, then go to `RUN`.
  - MULTU: same as MULT but unsigned.
  - DIV: `lo_tmp <= a/b` and `hi_tmp <= a%b`, signed. The quotient truncates toward zero and the remainder takes the dividend's sign. `cnt <= DIV_CYCLES`, then go to `RUN`.
  - DIVU: same as DIV but unsigned.
  - Divide by zero: `hi_tmp <= hi` and `lo_tmp <= lo`, so HI/LO are unchanged at commit. Full `DIV_CYCLES` busy still applies.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): `lo_tmp = 0x80000000`, `hi_tmp = 0`.
  - MTHI: `hi <= a` at this edge. No busy and no state change.
  - MTLO: `lo <= a` at this edge. No busy and no state change.
  - Codes 6–7: no effect.
- In `RUN`:
  - `cnt` decrements every cycle.
  - On the edge where `cnt==1`: `hi <= hi_tmp`, `lo <= lo_tmp`, `busy <= 0`, go to `IDLE`.
- `busy = (state==RUN)`, registered.
- `m_stall = d_md_use & (busy | (start & md_op<=3))`. This is combinational.
- Reset (active-low, synchronous) clears `hi`, `lo`, `hi_tmp`, `lo_tmp`, and `cnt`. It forces `IDLE` and `busy=0`. Reset mid-`RUN` aborts the operation: the result is never committed and HI/LO read 0.
- Reset has priority over `start` in the same cycle.

## Timing

- Reset values: `hi=0`, `lo=0`, `busy=0`. `m_stall` follows its equation, so it is 0 unless `d_md_use & start & md_op<=3`.
- Accepted mult/div start at edge T0:
  - `busy` is high from T0 through the edge T0+N, where N is the latency parameter, giving exactly N cycles.
  - `hi`/`lo` show the new result starting at T0+N.
  - `busy` falls at that same edge, T0+N.
- MTHI/MTLO: the value is visible in the cycle after the start edge. Zero stall.
- Back-to-back operations: a new start can be accepted in the first cycle after `busy` falls.
- MFHI/MFLO read `hi`/`lo` directly. The stall keeps them from reading a stale value during `RUN`.
- `hi`/`lo` are stable throughout `RUN` and keep the pre-operation values until commit.

## Test plan

- Reset then MULT: `reset=0` for 1 cycle, then `start`, `md_op=0`, `a=0xFFFFFFFE`(-2), `b=3`. Required: `busy` high exactly 5 cycles, `hi=0xFFFFFFFF` and `lo=0xFFFFFFFA` after the 5th edge, and old HI/LO (0) visible during busy.
- MULTU and DIVU:
  - MULTU with `a=b=0xFFFFFFFF` gives `hi=0xFFFFFFFE`, `lo=0x00000001`.
  - DIVU with `a=7`, `b=2` gives `lo=3`, `hi=1`, with `busy` for 10 cycles.
- Signed DIV edge cases:
  - `a=-7`, `b=2` gives `lo=0xFFFFFFFD`, `hi=0xFFFFFFFF`.
  - `a=0x80000000`, `b=0xFFFFFFFF` gives `lo=0x80000000`, `hi=0`.
  - `b=0` leaves HI/LO unchanged and keeps `busy` for 10 cycles.
- Stall and ignore:
  - During DIV `busy`, hold `d_md_use=1`. Required: `m_stall=1` every busy cycle and 0 the cycle after commit.
  - Pulse `start`, `md_op=4` mid-busy. Required: `hi` unaffected.
  - `d_md_use=1` with `start`, `md_op=0` in `IDLE` gives `m_stall=1` in that same cycle.
- MTHI/MTLO: MTHI `a=0x12345678`, then MTLO `a=0x9ABCDEF0` on the next cycle. Required: values visible 1 cycle after each, `busy` never asserted, `m_stall` stays 0.
- Reset mid-operation: MULT start, drive `reset=0` on the 3rd busy cycle. Required: `busy=0` and `hi=lo=0` at the next edge, no later commit, and a new MULT accepted normally afterward.
